// File: rtl/prg_loader_if.sv
// SDRAM write-side bus: toggle request/ack handshake between a loader (device)
// and the SDRAM controller.
interface sdram_bus #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
) ();
    logic              req;
    logic              ack;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_write;

    modport device (
        output req,
        output we,
        output address,
        output data_write,
        input  ack
    );

    modport controller (
        input  req,
        input  we,
        input  address,
        input  data_write,
        output ack
    );
endinterface

// File: rtl/prg_loader.sv
// PRG image loader: packs an incoming byte stream into 16-bit little-endian words
// and writes them to SDRAM over the toggle request/ack bus.
module prg_loader #(
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-2:0] base_addr,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-2:0] word_count,
    sdram_bus.device             ram
);
    localparam int WA = ADDR_BITS - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WA-1:0]   wptr_q, wptr_d;
    logic [WA-1:0]   word_count_q, word_count_d;
    logic            half_q, half_d;
    logic [7:0]      low_q, low_d;
    logic            pend_valid_q, pend_valid_d;
    logic [15:0]     pend_data_q, pend_data_d;
    logic            outstanding_q, outstanding_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [WA-1:0]   addr_q, addr_d;
    logic [15:0]     data_q, data_d;

    logic            bus_idle;
    logic            issue;
    logic            ready_c;
    logic            accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wptr_q        <= '0;
            word_count_q  <= '0;
            half_q        <= 1'b0;
            low_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_data_q   <= '0;
            outstanding_q <= 1'b0;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            word_count_q  <= word_count_d;
            half_q        <= half_d;
            low_q         <= low_d;
            pend_valid_q  <= pend_valid_d;
            pend_data_q   <= pend_data_d;
            outstanding_q <= outstanding_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        word_count_d  = word_count_q;
        half_d        = half_q;
        low_d         = low_q;
        pend_valid_d  = pend_valid_q;
        pend_data_d   = pend_data_q;
        outstanding_d = outstanding_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        data_d        = data_q;

        bus_idle = (ram.ack == req_q);
        issue    = pend_valid_q && bus_idle;
        // Any byte that completes a word (odd byte, or a padded final even byte)
        // needs a pending slot, which may be the one being freed this cycle.
        ready_c  = (state_q == S_ACTIVE) &&
                   (!pend_valid_q || issue || (!half_q && !in_last));
        accept   = in_valid && ready_c;

        if (outstanding_q && bus_idle) begin
            word_count_d  = word_count_q + WA'(1);
            outstanding_d = 1'b0;
        end

        if (issue) begin
            req_d         = ~req_q;
            we_d          = 1'b1;
            addr_d        = wptr_q;
            data_d        = pend_data_q;
            wptr_d        = wptr_q + WA'(1);
            pend_valid_d  = 1'b0;
            outstanding_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_ACTIVE;
                    wptr_d        = base_addr;
                    word_count_d  = '0;
                    half_d        = 1'b0;
                    pend_valid_d  = 1'b0;
                    outstanding_d = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (!half_q) begin
                        low_d  = in_data;
                        half_d = 1'b1;
                        if (in_last) begin
                            pend_data_d  = {8'hFF, in_data};
                            pend_valid_d = 1'b1;
                            half_d       = 1'b0;
                            state_d      = S_FLUSH;
                        end
                    end else begin
                        pend_data_d  = {in_data, low_q};
                        pend_valid_d = 1'b1;
                        half_d       = 1'b0;
                        if (in_last) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (!pend_valid_q && bus_idle) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready       = ready_c;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign word_count     = word_count_q;
    assign ram.req        = req_q;
    assign ram.we         = we_q;
    assign ram.address    = addr_q;
    assign ram.data_write = data_q;
endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader with a delayed-ack SDRAM responder and write log.
module tb_prg_loader;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [22:0] base_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [22:0] word_count;

    int n_cmp = 0;
    int n_err = 0;

    sdram_bus #(.ADDR_W(23), .DATA_W(16)) ram_if ();

    prg_loader #(.ADDR_BITS(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .ram        (ram_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          ack_delay = 1;
    int          ack_cnt   = 0;
    int          stable_err = 0;
    int          done_cnt  = 0;
    logic        last_req;
    logic [22:0] cur_addr;
    logic [15:0] cur_data;
    logic [22:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [7:0]  img[$];
    logic [15:0] stall_v;

    // SDRAM controller model: logs each new request, checks it stays stable,
    // and acks after ack_delay cycles.
    initial begin
        ram_if.ack = 1'b0;
        last_req   = 1'b0;
        cur_addr   = '0;
        cur_data   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ram_if.ack = 1'b0;
                last_req   = 1'b0;
                ack_cnt    = 0;
            end else begin
                if (ram_if.req != last_req) begin
                    last_req = ram_if.req;
                    cur_addr = ram_if.address;
                    cur_data = ram_if.data_write;
                    wr_addr.push_back(ram_if.address);
                    wr_data.push_back(ram_if.data_write);
                    ack_cnt = 0;
                end
                if (ram_if.req != ram_if.ack) begin
                    if (ram_if.address != cur_addr || ram_if.data_write != cur_data || ram_if.we !== 1'b1)
                        stable_err++;
                    ack_cnt++;
                    if (ack_cnt >= ack_delay) ram_if.ack = ram_if.req;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input int idx, input logic [22:0] ea, input logic [15:0] ed);
        if (idx < wr_addr.size()) begin
            check_eq($sformatf("wr%0d_addr", idx), {9'd0, wr_addr[idx]}, {9'd0, ea});
            check_eq($sformatf("wr%0d_data", idx), {16'd0, wr_data[idx]}, {16'd0, ed});
        end else begin
            check_eq($sformatf("wr%0d_missing", idx), 32'd0, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_in_ready"},   {31'd0, in_ready}, 32'd0);
        check_eq({pfx, "_busy"},       {31'd0, busy}, 32'd0);
        check_eq({pfx, "_done"},       {31'd0, done}, 32'd0);
        check_eq({pfx, "_word_count"}, {9'd0, word_count}, 32'd0);
        check_eq({pfx, "_req"},        {31'd0, ram_if.req}, 32'd0);
        check_eq({pfx, "_we"},         {31'd0, ram_if.we}, 32'd0);
        check_eq({pfx, "_address"},    {9'd0, ram_if.address}, 32'd0);
        check_eq({pfx, "_data_write"}, {16'd0, ram_if.data_write}, 32'd0);
    endtask

    task automatic pulse_start(input logic [22:0] b);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, output logic stalled);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        stalled = !in_ready;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_image();
        logic s;
        stall_v = '0;
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], (i == img.size() - 1), s);
            stall_v[i] = s;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy) check_eq("busy_timeout", 32'd1, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic new_test();
        wr_addr.delete();
        wr_data.delete();
        stable_err = 0;
    endtask

    int  d0;
    logic s;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Reset while a write is outstanding
        ack_delay = 20;
        new_test();
        pulse_start(23'h000010);
        send_byte(8'h01, 1'b0, s);
        send_byte(8'h02, 1'b0, s);
        repeat (2) @(negedge clk);
        check_eq("midwr_req_toggled", {31'd0, ram_if.req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 1;
        repeat (2) @(negedge clk);

        // Basic even-length image
        new_test();
        d0 = done_cnt;
        pulse_start(23'h000100);
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_image();
        wait_idle();
        check_eq("t2_nwrites", wr_addr.size(), 32'd2);
        check_write(0, 23'h000100, 16'h2211);
        check_write(1, 23'h000101, 16'h4433);
        check_eq("t2_word_count", {9'd0, word_count}, 32'd2);
        check_eq("t2_done_pulses", done_cnt - d0, 32'd1);
        check_eq("t2_stable", stable_err, 32'd0);

        // Odd-length image pads the last word
        new_test();
        d0 = done_cnt;
        pulse_start(23'h000200);
        img = '{8'hAA, 8'hBB, 8'hCC};
        send_image();
        wait_idle();
        check_eq("t3_nwrites", wr_addr.size(), 32'd2);
        check_write(0, 23'h000200, 16'hBBAA);
        check_write(1, 23'h000201, 16'hFFCC);
        check_eq("t3_word_count", {9'd0, word_count}, 32'd2);
        check_eq("t3_done_pulses", done_cnt - d0, 32'd1);

        // Slow ack: backpressure only on the 6th byte
        new_test();
        ack_delay = 10;
        d0 = done_cnt;
        pulse_start(23'h000300);
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_image();
        wait_idle();
        check_eq("t4_stall_pattern", {16'd0, stall_v}, 32'h0020);
        check_eq("t4_nwrites", wr_addr.size(), 32'd3);
        check_write(0, 23'h000300, 16'h0201);
        check_write(1, 23'h000301, 16'h0403);
        check_write(2, 23'h000302, 16'h0605);
        check_eq("t4_word_count", {9'd0, word_count}, 32'd3);
        check_eq("t4_stable", stable_err, 32'd0);
        check_eq("t4_done_pulses", done_cnt - d0, 32'd1);
        ack_delay = 1;

        // Address wrap at the top of PRG space
        new_test();
        pulse_start(23'h7FFFFF);
        img = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_image();
        wait_idle();
        check_eq("t5_nwrites", wr_addr.size(), 32'd2);
        check_write(0, 23'h7FFFFF, 16'h2010);
        check_write(1, 23'h000000, 16'h4030);

        // Start while busy must be ignored
        new_test();
        d0 = done_cnt;
        pulse_start(23'h000400);
        send_byte(8'h5A, 1'b0, s);
        pulse_start(23'h000055);
        check_eq("t6_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h6B, 1'b0, s);
        send_byte(8'h7C, 1'b0, s);
        send_byte(8'h8D, 1'b1, s);
        wait_idle();
        check_eq("t6_nwrites", wr_addr.size(), 32'd2);
        check_write(0, 23'h000400, 16'h6B5A);
        check_write(1, 23'h000401, 16'h8D7C);
        check_eq("t6_word_count", {9'd0, word_count}, 32'd2);
        check_eq("t6_done_pulses", done_cnt - d0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
